// File: rtl/hit_run_collector_pkg.sv
`default_nettype none
// ============================================================================
// hit_run_collector_pkg : shared state typedefs and drop-counter helper
// Revision: 1.0
// ============================================================================
package hit_run_collector_pkg;

    // Upstream count/assert FSM encoding
    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_COUNT  = 2'd1,
        ST_ASSERT = 2'd2
    } state_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } run_state_t;

    localparam int             c_DROP_W   = 4;
    localparam logic [3:0]     c_DROP_MAX = 4'hF;

    function automatic logic [c_DROP_W-1:0] sat_inc_drop(input logic [c_DROP_W-1:0] v);
        return (v == c_DROP_MAX) ? v : v + 4'd1;
    endfunction

endpackage : hit_run_collector_pkg
`default_nettype wire

// File: rtl/hit_len_fifo.sv
`default_nettype none
// ============================================================================
// hit_len_fifo : DEPTH-entry run-length FIFO, occupancy-based full/empty
// Revision: 1.0
// ============================================================================
module hit_len_fifo #(
    parameter int DEPTH = 4,
    parameter int LEN_W = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [LEN_W-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [LEN_W-1:0]           head_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int                  PTR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                  CNT_W       = $clog2(DEPTH) + 1;
    localparam logic [PTR_W-1:0]    c_PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0]    c_CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]    c_CNT_FULL  = CNT_W'(DEPTH);

    logic [LEN_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    // Caller guarantees push only when there is room (or a pop frees one),
    // and pop only when non-empty; pointers wrap naturally since DEPTH is 2^n.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + c_PTR_ONE;
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + c_PTR_ONE;
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + c_CNT_ONE;
            2'b01:   count_d = count_q - c_CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == c_CNT_FULL);
    assign empty_o = (count_q == '0);

endmodule : hit_len_fifo
`default_nettype wire

// File: rtl/hit_run_collector.sv
`default_nettype none
// ============================================================================
// hit_run_collector : measures lengths of consecutive-hit runs and queues them
// Revision: 1.0
// ============================================================================
module hit_run_collector
    import hit_run_collector_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LEN_W = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       hit_i,
    input  logic                       out_ready_i,
    output logic                       out_valid_o,
    output logic [LEN_W-1:0]           out_len_o,
    output logic [$clog2(DEPTH):0]     occupancy_o,
    output logic                       overflow_o,
    output logic [3:0]                 drop_cnt_o
);

    localparam logic [LEN_W-1:0] c_LEN_MAX = {LEN_W{1'b1}};
    localparam logic [LEN_W-1:0] c_LEN_ONE = LEN_W'(1);

    run_state_t         state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               overflow_q, overflow_d;
    logic [3:0]         drop_q, drop_d;

    logic               w_push_req;
    logic               w_push_ok;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        w_push_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (hit_i) begin
                    state_d = RUN;
                    len_d   = c_LEN_ONE;
                end
            end
            RUN: begin
                if (hit_i) begin
                    if (len_q != c_LEN_MAX) begin
                        len_d = len_q + c_LEN_ONE;
                    end
                end else begin
                    state_d    = IDLE;
                    w_push_req = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A full FIFO still accepts when the head leaves on the same edge.
    assign w_pop     = !w_empty && out_ready_i;
    assign w_push_ok = w_push_req && (!w_full || w_pop);

    always_comb begin
        overflow_d = overflow_q;
        drop_d     = drop_q;
        if (w_push_req && !w_push_ok) begin
            overflow_d = 1'b1;
            drop_d     = sat_inc_drop(drop_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            len_q      <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    hit_len_fifo #(
        .DEPTH (DEPTH),
        .LEN_W (LEN_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (w_push_ok),
        .push_data_i (len_q),
        .pop_i       (w_pop),
        .head_o      (out_len_o),
        .count_o     (occupancy_o),
        .full_o      (w_full),
        .empty_o     (w_empty)
    );

    assign out_valid_o = !w_empty;
    assign overflow_o  = overflow_q;
    assign drop_cnt_o  = drop_q;

endmodule : hit_run_collector
`default_nettype wire

// File: tb/tb_hit_run_collector.sv
`default_nettype none
// ============================================================================
// tb_hit_run_collector : directed scenarios plus random traffic vs. queue model
// Revision: 1.0
// ============================================================================
module tb_hit_run_collector;

    localparam int DEPTH  = 4;
    localparam int LEN_W  = 5;
    localparam int MAXLEN = (1 << LEN_W) - 1;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   hit_i = 1'b0;
    logic                   out_ready_i = 1'b0;
    logic                   out_valid_o;
    logic [LEN_W-1:0]       out_len_o;
    logic [$clog2(DEPTH):0] occupancy_o;
    logic                   overflow_o;
    logic [3:0]             drop_cnt_o;

    int n_vec = 0;
    int n_err = 0;

    int m_q[$];
    int m_run  = 0;
    int m_drop = 0;
    bit m_ovf  = 1'b0;

    hit_run_collector #(
        .DEPTH (DEPTH),
        .LEN_W (LEN_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hit_i       (hit_i),
        .out_ready_i (out_ready_i),
        .out_valid_o (out_valid_o),
        .out_len_o   (out_len_o),
        .occupancy_o (occupancy_o),
        .overflow_o  (overflow_o),
        .drop_cnt_o  (drop_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_model();
        check_eq("out_valid", {31'd0, out_valid_o}, (m_q.size() > 0) ? 32'd1 : 32'd0);
        check_eq("occupancy", 32'(occupancy_o), 32'(m_q.size()));
        if (m_q.size() > 0) begin
            check_eq("out_len", 32'(out_len_o), 32'(m_q[0]));
        end
        check_eq("overflow", {31'd0, overflow_o}, {31'd0, m_ovf});
        check_eq("drop_cnt", 32'(drop_cnt_o), 32'(m_drop));
    endtask

    // Called at a falling edge: check, drive, predict the next rising edge.
    task automatic step(input bit h, input bit r);
        bit pop;
        bit push;
        bit accept;
        int plen;
        check_model();
        hit_i       = h;
        out_ready_i = r;
        pop  = (m_q.size() > 0) && r;
        push = 1'b0;
        plen = 0;
        if (h) begin
            m_run = (m_run == 0) ? 1 : ((m_run < MAXLEN) ? m_run + 1 : MAXLEN);
        end else if (m_run > 0) begin
            push  = 1'b1;
            plen  = m_run;
            m_run = 0;
        end
        accept = push && ((m_q.size() < DEPTH) || pop);
        if (pop) void'(m_q.pop_front());
        if (accept) begin
            m_q.push_back(plen);
        end else if (push) begin
            m_ovf = 1'b1;
            if (m_drop < 15) m_drop++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2;
        rst_n       = 1'b0;
        hit_i       = 1'b0;
        out_ready_i = 1'b0;
        #1;
        check_eq("rst_valid", {31'd0, out_valid_o}, 32'd0);
        check_eq("rst_occ",   32'(occupancy_o), 32'd0);
        check_eq("rst_ovf",   {31'd0, overflow_o}, 32'd0);
        check_eq("rst_drop",  32'(drop_cnt_o), 32'd0);
        m_q.delete();
        m_run  = 0;
        m_drop = 0;
        m_ovf  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_of(input int len, input bit r);
        for (int i = 0; i < len; i++) step(1'b1, r);
        step(1'b0, r);
    endtask

    initial begin
        int exp_seq[3];
        repeat (2) @(negedge clk);
        do_reset();

        // Single run of 3, consumer ready
        run_of(3, 1'b1);
        check_eq("s1_valid", {31'd0, out_valid_o}, 32'd1);
        check_eq("s1_len",   32'(out_len_o), 32'd3);
        step(1'b0, 1'b1);
        check_eq("s1_drain", 32'(occupancy_o), 32'd0);

        // Runs 1, 2, 15 held, then drained in order
        run_of(1, 1'b0);
        run_of(2, 1'b0);
        run_of(15, 1'b0);
        check_eq("s2_occ", 32'(occupancy_o), 32'd3);
        exp_seq = '{1, 2, 15};
        for (int i = 0; i < 3; i++) begin
            check_eq("s2_order", 32'(out_len_o), 32'(exp_seq[i]));
            step(1'b0, 1'b1);
        end

        // Six runs of 2 into a 4-deep FIFO with no consumer
        do_reset();
        for (int i = 0; i < 6; i++) run_of(2, 1'b0);
        check_eq("s3_occ",  32'(occupancy_o), 32'd4);
        check_eq("s3_ovf",  {31'd0, overflow_o}, 32'd1);
        check_eq("s3_drop", 32'(drop_cnt_o), 32'd2);

        // Full FIFO: run ends on the same edge as a pop
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        check_eq("s4_occ",  32'(occupancy_o), 32'd4);
        check_eq("s4_drop", 32'(drop_cnt_o), 32'd2);

        // Saturating length
        do_reset();
        run_of(40, 1'b0);
        check_eq("s5_len", 32'(out_len_o), 32'd31);

        // Reset mid-run with entries queued
        do_reset();
        run_of(1, 1'b0);
        run_of(1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        check_eq("s6_occ_pre", 32'(occupancy_o), 32'd2);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1);
            check_eq("s6_no_len5", {31'd0, out_valid_o}, 32'd0);
        end

        // Random traffic with varying consumer pressure
        for (int seg = 0; seg < 12; seg++) begin
            int ready_pct;
            int hit_pct;
            ready_pct = (seg % 3 == 0) ? 5 : $urandom_range(20, 95);
            hit_pct   = $urandom_range(30, 90);
            if (seg == 6) do_reset();
            for (int i = 0; i < 80; i++) begin
                step(($urandom_range(0, 99) < hit_pct), ($urandom_range(0, 99) < ready_pct));
            end
        end
        check_model();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_hit_run_collector
`default_nettype wire

// File: doc/hit_run_collector.md
HIT_RUN_COLLECTOR -- requirements
Module: hit_run_collector

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the FIFO entry count; legal values are powers of two, 2..16.
REQ-002 Parameter LEN_W, default 5, SHALL set the run-length width in bits.
REQ-003 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 hit  input  1  SHALL carry the hit strobe from the upstream count/assert FSM, sampled every cycle.
REQ-006 out_ready  input  1  SHALL indicate that the consumer accepts out_len this cycle.
REQ-007 out_valid  output  1  SHALL be high when the FIFO holds at least one entry.
REQ-008 out_len  output  LEN_W  SHALL present the run length at the FIFO head; its value is don't-care when out_valid is low.
REQ-009 occupancy  output  $clog2(DEPTH)+1  SHALL give the current FIFO entry count.
REQ-010 overflow  output  1  SHALL be a sticky flag, set when any run length is dropped.
REQ-011 drop_cnt  output  4  SHALL give the number of dropped run lengths, saturating at 4'hF.

Function
REQ-012 The collector FSM SHALL have two states, IDLE and RUN.
REQ-013 IDLE, hit=1 -> RUN, len=1.
REQ-014 IDLE, hit=0 -> remain in IDLE; len holds.
REQ-015 RUN, hit=1 -> remain in RUN; len increments and saturates at 2^LEN_W-1 (31 by default), with no wrap.
REQ-016 RUN, hit=0 -> IDLE, and a push request with data=len is raised in the same cycle.
REQ-017 Latency: a run whose first low hit is sampled at edge N SHALL appear as out_valid=1 and out_len=len after edge N, provided the FIFO was empty.
REQ-018 Handshake: a pop SHALL occur when out_valid && out_ready at the rising edge; out_len and out_valid are driven directly from the FIFO head register and flags, with no combinational path from out_ready.
REQ-019 A push SHALL be accepted when occupancy<DEPTH, or when occupancy==DEPTH and a pop occurs in the same cycle.
REQ-020 A simultaneous push and pop SHALL leave occupancy unchanged.
REQ-021 A rejected push SHALL discard its data, set overflow, and increment drop_cnt (saturating); FIFO contents are not modified.
REQ-022 A pop while empty SHALL be impossible, because out_valid=0; out_ready is ignored in that case.
REQ-023 FIFO read and write pointers SHALL wrap modulo DEPTH; full and empty are derived from occupancy, not from pointer equality alone.
REQ-024 Entries SHALL be delivered in strict push order.
REQ-025 Once set, overflow SHALL clear only on reset.

Reset
REQ-026 reset low SHALL immediately force: state=IDLE, len=0, FIFO pointers=0, occupancy=0, out_valid=0, overflow=0, drop_cnt=0.
REQ-027 A run in progress when reset asserts SHALL be discarded, and all queued entries SHALL be lost.
REQ-028 Normal operation SHALL resume on the first rising edge after reset deasserts; the hit value sampled at that edge is treated as coming from IDLE.

Structure
REQ-029 The typedef RUN_STATE {IDLE, RUN} SHALL live in the shared package alongside the existing STATE typedef.
REQ-030 The FIFO SHALL be a sub-module named hit_len_fifo, parameterised by DEPTH and LEN_W, with ports push, push_data, pop, head, count, full, and empty.
REQ-031 The collector FSM, length counter, and drop accounting SHALL reside in hit_run_collector.

Verification
REQ-032 Scenario: hit high for 3 cycles then low, out_ready=1 -> a single beat with out_len=3, one cycle after the first low sample; occupancy returns to 0.
REQ-033 Scenario: runs of 1, 2, and 15 separated by 1-cycle gaps, out_ready=0 -> occupancy=3; then out_ready=1 -> out_len sequence 1, 2, 15 in that order.
REQ-034 Scenario: 6 runs of length 2, out_ready=0, DEPTH=4 -> occupancy=4, overflow=1, drop_cnt=2; the queued entries are the first four runs.
REQ-035 Scenario: FIFO full, out_ready=1 held, with a run ending in the same cycle as a pop -> push accepted, occupancy stays 4, drop_cnt unchanged.
REQ-036 Scenario: hit held high for 40 cycles -> out_len=31, with no wrap to a small value.
REQ-037 Scenario: reset pulsed low mid-run at len=5 with 2 entries queued -> out_valid=0 and occupancy=0 asynchronously; no entry of length 5 ever appears.
